gmii_rx_frame_checker: RTL

//  Consumes the GMII receive stream from the hps_gmii RGMII/GMII bridge: rxd/rxdv/rxer, plus col/crs ignored.

---
 rtl/gmii_rx_pkg.sv | 30 +++
 rtl/gmii_rx_frame_checker_if.sv | 20 ++
 rtl/crc32_d8.sv | 31 +++
 rtl/gmii_rx_frame_checker.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/gmii_rx_pkg.sv
// Shared types and constants for the GMII receive frame checker.
// Holds the FSM state encoding and the Ethernet CRC-32 constants and byte-update helper.
package gmii_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } rx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;

  // MSB-first register fed with each byte LSB-first, as the bits appear on the wire.
  // With this orientation a frame carrying a correct FCS leaves CRC_RESIDUE behind.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC32_POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/gmii_rx_frame_checker_if.sv
// Output byte stream of the GMII frame checker: one byte per valid pulse,
// framed by sop/eop, with error flag and frame length qualified by eop.
interface gmii_rx_frame_checker_if #(
  parameter int LEN_W = 11
);
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_sop;
  logic             out_eop;
  logic             out_err;
  logic [LEN_W-1:0] frame_len;

  modport master (
    output out_data, out_valid, out_sop, out_eop, out_err, frame_len
  );

  modport slave (
    input out_data, out_valid, out_sop, out_eop, out_err, frame_len
  );
endinterface

// File: rtl/crc32_d8.sv
// Byte-wide Ethernet CRC-32 register with init and enable; only built when
// GMII_RX_FCS_CHECK_EN is defined, since nothing else uses it.
`ifdef GMII_RX_FCS_CHECK_EN
module crc32_d8
  import gmii_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_reg, crc_next;

  always_comb begin
    crc_next = crc_reg;
    if (init)    crc_next = CRC_INIT;
    else if (en) crc_next = crc32_byte(crc_reg, data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_reg <= CRC_INIT;
    else        crc_reg <= crc_next;
  end

  assign crc = crc_reg;

endmodule
`endif

// File: rtl/gmii_rx_frame_checker.sv
// GMII receive frame checker: strips preamble/SFD, forwards frame bytes with sop/eop/err
// and keeps saturating good/bad frame counters. FCS checking is enabled by GMII_RX_FCS_CHECK_EN.
module gmii_rx_frame_checker
  import gmii_rx_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 32,
  parameter int LEN_W   = 11
) (
  input  logic                    peri_clock_clk,
  input  logic                    peri_reset_reset_n,
  input  logic                    rx_ce,
  input  logic [7:0]              gmii_rxd,
  input  logic                    gmii_rxdv,
  input  logic                    gmii_rxer,
  gmii_rx_frame_checker_if.master rx_out,
  output logic [CNT_W-1:0]        cnt_good,
  output logic [CNT_W-1:0]        cnt_bad,
  input  logic                    cnt_clr
);

  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  rx_state_t        state_reg, state_next;
  logic [7:0]       hold_reg;
  logic             have_reg;
  logic             first_reg;
  logic             rxer_flag_reg;
  logic [LEN_W-1:0] len_reg;

  logic [7:0]       out_data_reg;
  logic             out_valid_reg, out_sop_reg, out_eop_reg, out_err_reg;
  logic             empty_reg;
  logic [LEN_W-1:0] frame_len_reg;
  logic [CNT_W-1:0] cnt_good_reg, cnt_bad_reg;

  logic start_frame, data_beat, end_beat;
  logic emit, emit_eop, empty_end;
  logic fcs_bad, frame_bad;

`ifdef GMII_RX_FCS_CHECK_EN
  logic [31:0] crc_value;

  crc32_d8 u_crc (
    .clk   (peri_clock_clk),
    .rst_n (peri_reset_reset_n),
    .init  (start_frame),
    .en    (data_beat),
    .data  (gmii_rxd),
    .crc   (crc_value)
  );

  assign fcs_bad = (crc_value != CRC_RESIDUE);
`else
  assign fcs_bad = 1'b0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge peri_clock_clk or negedge peri_reset_reset_n) begin
    if (!peri_reset_reset_n) state_reg <= IDLE;
    else                     state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    if (rx_ce) begin
      case (state_reg)
        IDLE, PREAMBLE: begin
          if (!gmii_rxdv)                     state_next = IDLE;
          else if (gmii_rxd == PREAMBLE_BYTE) state_next = PREAMBLE;
          else if (gmii_rxd == SFD_BYTE)      state_next = DATA;
          else                                state_next = DROP;
        end
        DATA, DROP: begin
          if (!gmii_rxdv) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------- FSM: decoded controls ----------------
  always_comb begin
    start_frame = 1'b0;
    data_beat   = 1'b0;
    end_beat    = 1'b0;
    if (rx_ce) begin
      case (state_reg)
        IDLE, PREAMBLE: start_frame = gmii_rxdv && (gmii_rxd == SFD_BYTE);
        DATA: begin
          data_beat = gmii_rxdv;
          end_beat  = !gmii_rxdv;
        end
        default: ;
      endcase
    end
    // The skid byte only leaves when another beat arrives, so the last byte can carry eop.
    emit      = (data_beat || end_beat) && have_reg;
    emit_eop  = end_beat && have_reg;
    empty_end = end_beat && !have_reg;
  end

  assign frame_bad = rxer_flag_reg || (len_reg < LEN_MIN) || (len_reg > LEN_MAX) || fcs_bad;

  // Per-frame datapath: skid byte, sop tracking, sticky rxer and saturating length.
  always_ff @(posedge peri_clock_clk or negedge peri_reset_reset_n) begin
    if (!peri_reset_reset_n) begin
      hold_reg      <= 8'h00;
      have_reg      <= 1'b0;
      first_reg     <= 1'b0;
      rxer_flag_reg <= 1'b0;
      len_reg       <= '0;
    end else if (start_frame) begin
      have_reg      <= 1'b0;
      first_reg     <= 1'b1;
      rxer_flag_reg <= 1'b0;
      len_reg       <= '0;
    end else if (data_beat) begin
      hold_reg <= gmii_rxd;
      have_reg <= 1'b1;
      if (emit)              first_reg     <= 1'b0;
      if (gmii_rxer)         rxer_flag_reg <= 1'b1;
      if (len_reg != LEN_SAT) len_reg      <= len_reg + LEN_W'(1);
    end else if (end_beat) begin
      have_reg <= 1'b0;
    end
  end

  // Output strobes are single-cycle pulses; idle cycles drive zeros.
  always_ff @(posedge peri_clock_clk or negedge peri_reset_reset_n) begin
    if (!peri_reset_reset_n) begin
      out_data_reg  <= 8'h00;
      out_valid_reg <= 1'b0;
      out_sop_reg   <= 1'b0;
      out_eop_reg   <= 1'b0;
      out_err_reg   <= 1'b0;
      empty_reg     <= 1'b0;
      frame_len_reg <= '0;
    end else begin
      out_data_reg  <= emit ? hold_reg : 8'h00;
      out_valid_reg <= emit;
      out_sop_reg   <= emit && first_reg;
      out_eop_reg   <= emit_eop;
      out_err_reg   <= emit_eop && frame_bad;
      empty_reg     <= empty_end;
      if (emit_eop) frame_len_reg <= len_reg;
    end
  end

  // Counters act on the registered eop, so a clear raised while eop is visible wins.
  always_ff @(posedge peri_clock_clk or negedge peri_reset_reset_n) begin
    if (!peri_reset_reset_n) begin
      cnt_good_reg <= '0;
      cnt_bad_reg  <= '0;
    end else if (cnt_clr) begin
      cnt_good_reg <= '0;
      cnt_bad_reg  <= '0;
    end else begin
      if (out_eop_reg && !out_err_reg && (cnt_good_reg != '1))
        cnt_good_reg <= cnt_good_reg + CNT_W'(1);
      if (((out_eop_reg && out_err_reg) || empty_reg) && (cnt_bad_reg != '1))
        cnt_bad_reg <= cnt_bad_reg + CNT_W'(1);
    end
  end

  assign rx_out.out_data  = out_data_reg;
  assign rx_out.out_valid = out_valid_reg;
  assign rx_out.out_sop   = out_sop_reg;
  assign rx_out.out_eop   = out_eop_reg;
  assign rx_out.out_err   = out_err_reg;
  assign rx_out.frame_len = frame_len_reg;
  assign cnt_good         = cnt_good_reg;
  assign cnt_bad          = cnt_bad_reg;

endmodule
